// File: rtl/ppu_pkg.sv
// Shared PPU constants, sprite evaluator state type and the Y range helper.
package ppu_pkg;

    localparam int unsigned OAM_SPRITES      = 64;
    localparam int unsigned MAX_LINE_SPRITES = 8;
    localparam int unsigned SEC_OAM_BYTES    = 32;
    localparam int unsigned SPRITE_H_SMALL   = 8;
    localparam int unsigned SPRITE_H_LARGE   = 16;

    localparam int unsigned OAM_AW   = 8;
    localparam int unsigned SEC_AW   = 5;
    localparam int unsigned LINE_W   = 9;
    localparam int unsigned COUNT_W  = 4;
    localparam int unsigned SPRITE_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_CHECK_Y  = 3'd2,
        ST_COPY     = 3'd3,
        ST_OVF_SCAN = 3'd4,
        ST_DONE     = 3'd5
    } sprite_eval_state_t;

    // Row is taken modulo 512 so a Y above the current line never aliases into range.
    function automatic logic y_in_range(input logic [LINE_W-1:0] line,
                                        input logic [7:0]        y,
                                        input logic              size);
        logic [LINE_W-1:0] row;
        row = line - {1'b0, y};
        return row < (size ? LINE_W'(SPRITE_H_LARGE) : LINE_W'(SPRITE_H_SMALL));
    endfunction

endpackage

// File: rtl/secondary_oam.sv
// 32x8 secondary OAM: synchronous write on dot ticks, combinational read.
module secondary_oam
    import ppu_pkg::*;
(
    input  logic              clk,
    input  logic              dot_tick,
    input  logic              we,
    input  logic [SEC_AW-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [SEC_AW-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [SEC_OAM_BYTES];

    // Write port, advanced only on a PPU dot.
    always_ff @(posedge clk) begin
        if (we && dot_tick) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sprite_evaluator.sv
// Per-scanline sprite evaluation: clears secondary OAM, copies up to eight
// in-range sprites from primary OAM, then scans the rest for overflow.
module sprite_evaluator
    import ppu_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               dot_tick,
    input  logic               line_start,
    input  logic               render_en,
    input  logic [LINE_W-1:0]  line_count,
    input  logic               sprite_size,
    output logic [OAM_AW-1:0]  oam_rd_addr,
    input  logic [7:0]         oam_rd_data,
    input  logic [SEC_AW-1:0]  sec_rd_addr,
    output logic [7:0]         sec_rd_data,
    output logic [COUNT_W-1:0] sprite_count,
    output logic               sprite0_hit_line,
    output logic               overflow_set,
    output logic               eval_done
);

    sprite_eval_state_t    state_q, state_d;
    logic [SPRITE_W-1:0]   n_q, n_d;
    logic [1:0]            sub_q, sub_d;
    logic [SEC_AW-1:0]     clr_q, clr_d;
    logic [COUNT_W-1:0]    found_q, found_d;
    logic [COUNT_W-1:0]    count_d;
    logic                  hit_d, done_d, ovf_d;
    logic                  sec_we_c;
    logic [SEC_AW-1:0]     sec_wa_c;
    logic [7:0]            sec_wd_c;
    logic                  in_range_c;
    logic                  n_last_c;

    secondary_oam u_sec (
        .clk      (CLK),
        .dot_tick (dot_tick),
        .we       (sec_we_c),
        .wr_addr  (sec_wa_c),
        .wr_data  (sec_wd_c),
        .rd_addr  (sec_rd_addr),
        .rd_data  (sec_rd_data)
    );

    // State and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q          <= ST_IDLE;
            n_q              <= '0;
            sub_q            <= '0;
            clr_q            <= '0;
            found_q          <= '0;
            sprite_count     <= '0;
            sprite0_hit_line <= 1'b0;
            eval_done        <= 1'b0;
            overflow_set     <= 1'b0;
        end else begin
            state_q          <= state_d;
            n_q              <= n_d;
            sub_q            <= sub_d;
            clr_q            <= clr_d;
            found_q          <= found_d;
            sprite_count     <= count_d;
            sprite0_hit_line <= hit_d;
            eval_done        <= done_d;
            overflow_set     <= ovf_d;
        end
    end

    // Next-state, counters and secondary OAM write control.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        sub_d      = sub_q;
        clr_d      = clr_q;
        found_d    = found_q;
        count_d    = sprite_count;
        hit_d      = sprite0_hit_line;
        done_d     = eval_done;
        ovf_d      = 1'b0;
        sec_we_c   = 1'b0;
        sec_wa_c   = '0;
        sec_wd_c   = 8'hFF;
        in_range_c = y_in_range(line_count, oam_rd_data, sprite_size);
        n_last_c   = (n_q == SPRITE_W'(OAM_SPRITES - 1));

        if (dot_tick) begin
            if (!render_en) begin
                state_d = ST_IDLE;
                n_d     = '0;
                sub_d   = '0;
                found_d = '0;
                count_d = '0;
                hit_d   = 1'b0;
                done_d  = 1'b0;
            end else if (line_start) begin
                state_d = ST_CLEAR;
                clr_d   = '0;
                n_d     = '0;
                sub_d   = '0;
                found_d = '0;
                count_d = '0;
                hit_d   = 1'b0;
                done_d  = 1'b0;
            end else begin
                case (state_q)
                    ST_CLEAR: begin
                        sec_we_c = 1'b1;
                        sec_wa_c = clr_q;
                        clr_d    = SEC_AW'(clr_q + 1'b1);
                        if (clr_q == SEC_AW'(SEC_OAM_BYTES - 1)) begin
                            state_d = ST_CHECK_Y;
                        end
                    end
                    ST_CHECK_Y: begin
                        if (in_range_c) begin
                            sec_we_c = 1'b1;
                            sec_wa_c = {found_q[2:0], 2'b00};
                            sec_wd_c = oam_rd_data;
                            sub_d    = 2'd1;
                            state_d  = ST_COPY;
                            if (n_q == '0) begin
                                hit_d = 1'b1;
                            end
                        end else begin
                            n_d = SPRITE_W'(n_q + 1'b1);
                            if (n_last_c) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                                count_d = found_q;
                            end
                        end
                    end
                    ST_COPY: begin
                        sec_we_c = 1'b1;
                        sec_wa_c = {found_q[2:0], sub_q};
                        sec_wd_c = oam_rd_data;
                        sub_d    = 2'(sub_q + 1'b1);
                        if (sub_q == 2'd3) begin
                            found_d = COUNT_W'(found_q + 1'b1);
                            n_d     = SPRITE_W'(n_q + 1'b1);
                            if (n_last_c) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                                count_d = found_d;
                            end else if (found_d == COUNT_W'(MAX_LINE_SPRITES)) begin
                                state_d = ST_OVF_SCAN;
                            end else begin
                                state_d = ST_CHECK_Y;
                            end
                        end
                    end
                    ST_OVF_SCAN: begin
                        if (in_range_c) begin
                            ovf_d   = 1'b1;
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            count_d = found_q;
                        end else begin
                            n_d = SPRITE_W'(n_q + 1'b1);
                            if (n_last_c) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                                count_d = found_q;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Primary OAM address is a decode of registered state; zero when not reading.
    always_comb begin
        oam_rd_addr = '0;
        case (state_q)
            ST_CHECK_Y, ST_OVF_SCAN: oam_rd_addr = {n_q, 2'b00};
            ST_COPY:                 oam_rd_addr = {n_q, sub_q};
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sprite_evaluator.sv
// Self-checking bench for sprite_evaluator: directed table, corner sequences,
// and random OAM scenes against a sprite-list reference model.
module tb_sprite_evaluator;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       dot_tick;
    logic       line_start;
    logic       render_en;
    logic [8:0] line_count;
    logic       sprite_size;
    logic [7:0] oam_rd_addr;
    logic [7:0] oam_rd_data;
    logic [4:0] sec_rd_addr;
    logic [7:0] sec_rd_data;
    logic [3:0] sprite_count;
    logic       sprite0_hit_line;
    logic       overflow_set;
    logic       eval_done;

    logic [7:0] oam [256];
    logic [7:0] exp_sec [32];
    int         exp_count;
    int         exp_hit;
    int         exp_ovf;
    int         exp_ticks;
    int         ovf_pulses = 0;
    int         n_checks = 0;
    int         n_fails = 0;

    typedef struct {
        int         line;
        logic       size;
        logic [7:0] y;
        int         exp_count;
        int         exp_hit;
    } vec_t;

    vec_t vecs [10];

    sprite_evaluator dut (
        .CLK              (CLK),
        .RST              (rst_n),
        .dot_tick         (dot_tick),
        .line_start       (line_start),
        .render_en        (render_en),
        .line_count       (line_count),
        .sprite_size      (sprite_size),
        .oam_rd_addr      (oam_rd_addr),
        .oam_rd_data      (oam_rd_data),
        .sec_rd_addr      (sec_rd_addr),
        .sec_rd_data      (sec_rd_data),
        .sprite_count     (sprite_count),
        .sprite0_hit_line (sprite0_hit_line),
        .overflow_set     (overflow_set),
        .eval_done        (eval_done)
    );

    always #5 CLK = ~CLK;

    assign oam_rd_data = oam[oam_rd_addr];

    always @(negedge CLK) begin
        if (overflow_set) ovf_pulses++;
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // One dot tick followed by one idle clock; returns just after a falling edge.
    task automatic do_tick(input logic ls);
        @(negedge CLK);
        dot_tick   = 1'b1;
        line_start = ls;
        @(negedge CLK);
        dot_tick   = 1'b0;
        line_start = 1'b0;
        #1;
    endtask

    task automatic wait_done(output int ticks);
        ticks = 0;
        while (!eval_done && ticks < 200) begin
            do_tick(1'b0);
            ticks++;
        end
    endtask

    // Reference: walk the sprite list, keep the first eight hits, and look for a ninth.
    task automatic model(input int line, input logic size);
        int h, f, stop;
        h = size ? 16 : 8;
        f = 0;
        stop = 0;
        exp_ticks = 32;
        exp_hit = 0;
        exp_ovf = 0;
        for (int b = 0; b < 32; b++) exp_sec[b] = 8'hFF;
        for (int i = 0; i < 64; i++) begin
            int row;
            int inr;
            if (stop == 0) begin
                row = (((line - int'(oam[4*i])) % 512) + 512) % 512;
                inr = (row < h) ? 1 : 0;
                if (f < 8) begin
                    exp_ticks += inr ? 4 : 1;
                    if (inr != 0) begin
                        if (i == 0) exp_hit = 1;
                        for (int b = 0; b < 4; b++) exp_sec[f*4+b] = oam[4*i+b];
                        f++;
                    end
                end else begin
                    exp_ticks += 1;
                    if (inr != 0) begin
                        exp_ovf = 1;
                        stop = 1;
                    end
                end
            end
        end
        exp_count = f;
    endtask

    task automatic fill_filler(input int line);
        for (int s = 0; s < 64; s++) begin
            oam[4*s]   = 8'(line + 20);
            oam[4*s+1] = 8'($urandom);
            oam[4*s+2] = 8'($urandom);
            oam[4*s+3] = 8'($urandom);
        end
    endtask

    task automatic check_sec();
        for (int b = 0; b < 32; b++) begin
            sec_rd_addr = 5'(b);
            #1;
            check("sec_byte", int'(sec_rd_data), int'(exp_sec[b]));
        end
    endtask

    // Full evaluation of the current OAM contents compared with the model.
    task automatic run_scene(input int line, input logic size);
        int ticks, p0;
        line_count  = 9'(line);
        sprite_size = size;
        model(line, size);
        p0 = ovf_pulses;
        do_tick(1'b1);
        check("done_cleared", int'(eval_done), 0);
        wait_done(ticks);
        check("eval_done", int'(eval_done), 1);
        check("done_ticks", ticks, exp_ticks);
        check("sprite_count", int'(sprite_count), exp_count);
        check("sprite0_hit", int'(sprite0_hit_line), exp_hit);
        check("ovf_pulses", ovf_pulses - p0, exp_ovf);
        check("addr_done", int'(oam_rd_addr), 0);
        check_sec();
    endtask

    initial begin
        int ticks, p0;
        rst_n       = 1'b0;
        dot_tick    = 1'b0;
        line_start  = 1'b0;
        render_en   = 1'b1;
        line_count  = 9'd100;
        sprite_size = 1'b0;
        sec_rd_addr = '0;
        for (int i = 0; i < 256; i++) oam[i] = 8'hEE;

        vecs[0] = '{100, 1'b0, 8'd120, 0, 0};
        vecs[1] = '{100, 1'b0, 8'd99,  1, 1};
        vecs[2] = '{100, 1'b0, 8'd90,  0, 0};
        vecs[3] = '{100, 1'b1, 8'd90,  1, 1};
        vecs[4] = '{100, 1'b0, 8'd92,  0, 0};
        vecs[5] = '{100, 1'b0, 8'd93,  1, 1};
        vecs[6] = '{100, 1'b1, 8'd84,  0, 0};
        vecs[7] = '{5,   1'b1, 8'd255, 0, 0};
        vecs[8] = '{250, 1'b0, 8'd245, 1, 1};
        vecs[9] = '{0,   1'b0, 8'd0,   1, 1};

        #23;
        check("rst_addr", int'(oam_rd_addr), 0);
        check("rst_count", int'(sprite_count), 0);
        check("rst_hit", int'(sprite0_hit_line), 0);
        check("rst_ovf", int'(overflow_set), 0);
        check("rst_done", int'(eval_done), 0);
        rst_n = 1'b1;

        // No evaluation without a line_start after reset.
        for (int i = 0; i < 5; i++) do_tick(1'b0);
        check("idle_done", int'(eval_done), 0);
        check("idle_addr", int'(oam_rd_addr), 0);

        // Directed single-sprite table.
        for (int v = 0; v < 10; v++) begin
            logic [7:0] e0;
            fill_filler(vecs[v].line);
            oam[0] = vecs[v].y;
            oam[1] = 8'h12;
            oam[2] = 8'h03;
            oam[3] = 8'h40;
            run_scene(vecs[v].line, vecs[v].size);
            check("tbl_count", int'(sprite_count), vecs[v].exp_count);
            check("tbl_hit", int'(sprite0_hit_line), vecs[v].exp_hit);
            e0 = (vecs[v].exp_count != 0) ? vecs[v].y : 8'hFF;
            sec_rd_addr = 5'd0; #1;
            check("tbl_sec0", int'(sec_rd_data), int'(e0));
            sec_rd_addr = 5'd1; #1;
            check("tbl_sec1", int'(sec_rd_data), (vecs[v].exp_count != 0) ? 'h12 : 'hFF);
            sec_rd_addr = 5'd3; #1;
            check("tbl_sec3", int'(sec_rd_data), (vecs[v].exp_count != 0) ? 'h40 : 'hFF);
        end

        // Ten sprites on one line: eight kept, one overflow pulse.
        fill_filler(55);
        for (int s = 0; s < 10; s++) oam[4*s] = 8'd50;
        p0 = ovf_pulses;
        run_scene(55, 1'b0);
        check("ovf10_count", int'(sprite_count), 8);
        check("ovf10_pulse", ovf_pulses - p0, 1);

        // Disabling rendering clears the reported results.
        render_en = 1'b0;
        do_tick(1'b0);
        check("rdis_count", int'(sprite_count), 0);
        check("rdis_hit", int'(sprite0_hit_line), 0);
        check("rdis_done", int'(eval_done), 0);
        render_en = 1'b1;

        // Exactly eight in range: full scan, no pulse.
        fill_filler(55);
        for (int s = 0; s < 8; s++) oam[4*s] = 8'd50;
        p0 = ovf_pulses;
        run_scene(55, 1'b0);
        check("ovf8_count", int'(sprite_count), 8);
        check("ovf8_pulse", ovf_pulses - p0, 0);

        // Abort mid-evaluation restarts the clear.
        fill_filler(100);
        oam[0] = 8'd97;
        line_count = 9'd100;
        sprite_size = 1'b0;
        do_tick(1'b1);
        for (int i = 0; i < 40; i++) do_tick(1'b0);
        sec_rd_addr = 5'd0; #1;
        check("abort_pre_sec0", int'(sec_rd_data), 97);
        do_tick(1'b1);
        do_tick(1'b0);
        sec_rd_addr = 5'd0; #1;
        check("abort_sec0", int'(sec_rd_data), 'hFF);
        check("abort_done", int'(eval_done), 0);
        model(100, 1'b0);
        wait_done(ticks);
        check("abort_ticks", ticks + 1, exp_ticks);
        check("abort_count", int'(sprite_count), exp_count);
        check_sec();

        // Asynchronous reset in the middle of a copy.
        fill_filler(100);
        oam[0] = 8'd99;
        do_tick(1'b1);
        for (int i = 0; i < 34; i++) do_tick(1'b0);
        check("copy_addr", int'(oam_rd_addr), 2);
        check("copy_hit", int'(sprite0_hit_line), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_addr", int'(oam_rd_addr), 0);
        check("arst_hit", int'(sprite0_hit_line), 0);
        check("arst_count", int'(sprite_count), 0);
        check("arst_done", int'(eval_done), 0);
        check("arst_ovf", int'(overflow_set), 0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) do_tick(1'b0);
        check("arst_idle_done", int'(eval_done), 0);
        check("arst_idle_addr", int'(oam_rd_addr), 0);

        // Random scenes biased towards in-range sprites.
        for (int r = 0; r < 20; r++) begin
            int line;
            logic size;
            line = int'($urandom_range(0, 261));
            size = 1'($urandom_range(0, 1));
            for (int s = 0; s < 64; s++) begin
                if ($urandom_range(0, 3) == 0)
                    oam[4*s] = 8'(line - int'($urandom_range(0, 17)));
                else
                    oam[4*s] = 8'($urandom);
                oam[4*s+1] = 8'($urandom);
                oam[4*s+2] = 8'($urandom);
                oam[4*s+3] = 8'($urandom);
            end
            run_scene(line, size);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
